// File: rtl/mvm_pkg.sv
// Shared types and constant helpers for the batched matrix-vector engine.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package mvm_pkg;

   // Job sequencing states of the top-level controller
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_X = 3'd1,
      ST_MAC    = 3'd2,
      ST_OUT    = 3'd3,
      ST_DONE   = 3'd4
   } mvm_state_t;

   // clog2 that never returns 0, so a single-entry dimension still gets a 1-bit index
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Weight address width: row*COLS+col
   function automatic int addr_w(input int rows, input int cols);
      return clog2_min1(rows * cols);
   endfunction

   // Column (k) counter width
   function automatic int k_w(input int cols);
      return clog2_min1(cols);
   endfunction

   // Largest positive value of an acc_w-bit signed accumulator
   function automatic longint sat_max(input int acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   // Most negative value of an acc_w-bit signed accumulator
   function automatic longint sat_min(input int acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/mvm_if.sv
// Preload, input-vector and result ready/valid channels of the MVM engine.
// Latency: n/a (wiring only).
// Backpressure: each channel is a plain valid/ready pair.
interface mvm_if
   import mvm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int ACC_W = 20
) ();

   localparam int AW = addr_w(ROWS, COLS);

   logic                     preload_valid;
   logic                     preload_ready;
   logic [AW-1:0]            preload_addr;
   logic signed [DW-1:0]     preload_data;

   logic                     x_valid;
   logic                     x_ready;
   logic [COLS*DW-1:0]       x_vector_flat;

   logic                     result_valid;
   logic                     result_ready;
   logic [ROWS*ACC_W-1:0]    result_flat;

   // Host / consumer side
   modport master (
      output preload_valid, preload_addr, preload_data,
      output x_valid, x_vector_flat,
      output result_ready,
      input  preload_ready, x_ready, result_valid, result_flat
   );

   // Engine side
   modport slave (
      input  preload_valid, preload_addr, preload_data,
      input  x_valid, x_vector_flat,
      input  result_ready,
      output preload_ready, x_ready, result_valid, result_flat
   );

endinterface

// File: rtl/mvm_row_mac.sv
// One accumulator lane: acc += w*x per enabled cycle, saturating or wrapping.
// Latency: 1 cycle per MAC step (registered accumulator).
// Backpressure: none; the controller gates clr_i/en_i.
module mvm_row_mac
   import mvm_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ACC_W = 20,
   parameter bit SAT   = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    en_i,
   input  logic signed [DW-1:0]    w_i,
   input  logic signed [DW-1:0]    x_i,
   output logic signed [ACC_W-1:0] acc_o
);

   localparam longint MAX_V = sat_max(ACC_W);
   localparam longint MIN_V = sat_min(ACC_W);
   localparam logic signed [ACC_W:0] MAX_L = MAX_V[ACC_W:0];
   localparam logic signed [ACC_W:0] MIN_L = MIN_V[ACC_W:0];

   logic signed [2*DW-1:0]  w_ext;
   logic signed [2*DW-1:0]  x_ext;
   logic signed [2*DW-1:0]  prod;
   logic signed [ACC_W:0]   sum;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   // Next accumulator: clear on vector capture, else one MAC step with clamp or wrap
   always_comb begin
      w_ext = {{DW{w_i[DW-1]}}, w_i};
      x_ext = {{DW{x_i[DW-1]}}, x_i};
      prod  = w_ext * x_ext;
      // One guard bit above ACC_W so the clamp sees the true sum
      sum   = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-2*DW){prod[2*DW-1]}}, prod};
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         if (SAT && (sum > MAX_L)) begin
            acc_d = MAX_L[ACC_W-1:0];
         end else if (SAT && (sum < MIN_L)) begin
            acc_d = MIN_L[ACC_W-1:0];
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end
   end

   // Accumulator register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/mvm_batch_top.sv
// Batched matrix-vector engine: preloaded ROWSxCOLS weights times batch_len vectors.
// Latency: vector accepted at edge t -> result_valid from cycle t+COLS+1.
// Backpressure: OUT holds until result_ready; no new vector taken while a result is pending.
module mvm_batch_top
   import mvm_pkg::*;
#(
   parameter int DW      = 8,
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int ACC_W   = 20,
   parameter int BATCH_W = 4,
   parameter bit SAT     = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [BATCH_W-1:0] batch_len,
   output logic               busy,
   output logic               done,
   mvm_if.slave               bus
);

   localparam int NW = ROWS * COLS;
   localparam int AW = addr_w(ROWS, COLS);
   localparam int KW = k_w(COLS);

   mvm_state_t           state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic [BATCH_W-1:0]   cnt_q, cnt_d;
   logic [BATCH_W-1:0]   len_q, len_d;
   logic signed [DW-1:0] w_q [NW];
   logic signed [DW-1:0] w_d [NW];
   logic signed [DW-1:0] x_q [COLS];
   logic signed [DW-1:0] x_d [COLS];
   logic signed [DW-1:0] w_sel [ROWS];
   logic signed [DW-1:0] x_sel;
   logic signed [ACC_W-1:0] acc [ROWS];

   logic job_acc;
   logic x_acc;
   logic out_acc;
   logic we;
   logic mac_en;

   // Handshake decodes and next values of weights, operands and counters
   always_comb begin
      job_acc = (state_q == ST_IDLE) && start && (batch_len != '0);
      x_acc   = (state_q == ST_LOAD_X) && bus.x_valid;
      out_acc = (state_q == ST_OUT) && bus.result_ready;
      we      = (state_q == ST_IDLE) && bus.preload_valid;
      mac_en  = (state_q == ST_MAC);

      // Addresses beyond the last weight match no entry and are dropped
      w_d = w_q;
      for (int i = 0; i < NW; i++) begin
         if (we && (bus.preload_addr == AW'(i))) begin
            w_d[i] = bus.preload_data;
         end
      end

      x_d = x_q;
      if (x_acc) begin
         for (int c = 0; c < COLS; c++) begin
            x_d[c] = bus.x_vector_flat[c*DW +: DW];
         end
      end

      k_d = k_q;
      if (x_acc) begin
         k_d = '0;
      end else if (mac_en) begin
         k_d = k_q + KW'(1);
      end

      cnt_d = cnt_q;
      if (job_acc) begin
         cnt_d = '0;
      end else if (out_acc) begin
         cnt_d = cnt_q + BATCH_W'(1);
      end

      len_d = len_q;
      if (job_acc) begin
         len_d = batch_len;
      end
   end

   // Column k of every row and element k of the vector feed the lanes this cycle
   always_comb begin
      x_sel = '0;
      for (int c = 0; c < COLS; c++) begin
         if (k_q == KW'(c)) begin
            x_sel = x_q[c];
         end
      end
      for (int r = 0; r < ROWS; r++) begin
         w_sel[r] = '0;
         for (int c = 0; c < COLS; c++) begin
            if (k_q == KW'(c)) begin
               w_sel[r] = w_q[r*COLS + c];
            end
         end
      end
   end

   // Job sequencing: IDLE -> (LOAD_X -> MAC x COLS -> OUT) x batch_len -> DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (job_acc) state_d = ST_LOAD_X;
         ST_LOAD_X: if (bus.x_valid) state_d = ST_MAC;
         ST_MAC:    if (k_q == KW'(COLS - 1)) state_d = ST_OUT;
         ST_OUT: begin
            if (bus.result_ready) begin
               state_d = ((cnt_q + BATCH_W'(1)) == len_q) ? ST_DONE : ST_LOAD_X;
            end
         end
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Status and handshake outputs decode straight from the state register
   always_comb begin
      bus.preload_ready = (state_q == ST_IDLE);
      bus.x_ready       = (state_q == ST_LOAD_X);
      bus.result_valid  = (state_q == ST_OUT);
      busy              = (state_q != ST_IDLE);
      done              = (state_q == ST_DONE);
      bus.result_flat   = '0;
      for (int r = 0; r < ROWS; r++) begin
         bus.result_flat[r*ACC_W +: ACC_W] = acc[r];
      end
   end

   // State, counters and captured operands; reset also wipes the weights
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         for (int i = 0; i < NW; i++) begin
            w_q[i] <= '0;
         end
         for (int c = 0; c < COLS; c++) begin
            x_q[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         w_q     <= w_d;
         x_q     <= x_d;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_lane
      mvm_row_mac #(
         .DW    (DW),
         .ACC_W (ACC_W),
         .SAT   (SAT)
      ) u_mac (
         .clk   (clk),
         .rst_n (rst_n),
         .clr_i (x_acc),
         .en_i  (mac_en),
         .w_i   (w_sel[r]),
         .x_i   (x_sel),
         .acc_o (acc[r])
      );
   end

endmodule
